// File: rtl/dut_fsm_test_ctrl.sv
// Run-level sequencer for the DUT FSM test path: arms the checker, drives the
// 1,2,3 stimulus pattern for a programmed number of windows and counts errors.
module dut_fsm_test_ctrl #(
  parameter int IO_SIZE_G = 4,
  parameter int WIN_W     = 16,
  parameter int ERRCNT_W  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [WIN_W-1:0]     num_windows_i,
  input  logic                 inject_i,
  input  logic                 err_data_i,
  input  logic                 err_state_i,
  output logic                 chk_rst_o,
  output logic [IO_SIZE_G-1:0] data_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [WIN_W-1:0]     win_cnt_o,
  output logic [ERRCNT_W-1:0]  err_data_cnt_o,
  output logic [ERRCNT_W-1:0]  err_state_cnt_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARM   = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [IO_SIZE_G-1:0] TICK_MAX  = {IO_SIZE_G{1'b1}};
  localparam logic [IO_SIZE_G-1:0] TICK_ONE  = IO_SIZE_G'(1);
  localparam logic [IO_SIZE_G-1:0] PAT_ONE   = IO_SIZE_G'(1);
  localparam logic [IO_SIZE_G-1:0] PAT_TWO   = IO_SIZE_G'(2);
  localparam logic [IO_SIZE_G-1:0] PAT_THREE = IO_SIZE_G'(3);
  localparam logic [IO_SIZE_G-1:0] PAT_INJ   = IO_SIZE_G'(4);
  localparam logic [WIN_W-1:0]     WIN_ONE   = WIN_W'(1);
  localparam logic [ERRCNT_W-1:0]  ERR_ONE   = ERRCNT_W'(1);

  function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
    return (v == {ERRCNT_W{1'b1}}) ? v : v + ERR_ONE;
  endfunction

  logic [2:0]           state_q, state_d;
  logic                 arm_q, arm_d;
  logic [1:0]           drain_q, drain_d;
  logic [IO_SIZE_G-1:0] tick_q, tick_d;
  logic                 inj_q, inj_d;
  logic [WIN_W-1:0]     num_q, num_d;
  logic [WIN_W-1:0]     win_q, win_d;
  logic [WIN_W-1:0]     win_inc_s;
  logic [ERRCNT_W-1:0]  errd_q, errd_d;
  logic [ERRCNT_W-1:0]  errs_q, errs_d;
  logic [IO_SIZE_G-1:0] data_q, data_d;
  logic                 chk_rst_q, chk_rst_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  assign win_inc_s = win_q + WIN_ONE;

  // Next-state, counter and stimulus computation
  always_comb begin
    state_d = state_q;
    arm_d   = arm_q;
    drain_d = drain_q;
    tick_d  = tick_q;
    inj_d   = inj_q;
    num_d   = num_q;
    win_d   = win_q;
    errd_d  = errd_q;
    errs_d  = errs_q;
    data_d  = '0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_ARM;
          num_d   = num_windows_i;
          win_d   = '0;
          errd_d  = '0;
          errs_d  = '0;
          tick_d  = '0;
          inj_d   = 1'b0;
          arm_d   = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      S_ARM: begin
        if (arm_q) begin
          state_d = (num_q == '0) ? S_DONE : S_RUN;
        end else begin
          arm_d = 1'b1;
        end
      end
      S_RUN: begin
        tick_d = tick_q + TICK_ONE;
        if (inject_i) begin
          inj_d = 1'b1;
        end else begin
          inj_d = inj_q;
        end
        // Abort drops the partial window; data goes quiet for the drain
        if (abort_i) begin
          state_d = S_DRAIN;
          drain_d = 2'd0;
        end else begin
          if (tick_q == TICK_MAX) begin
            win_d = win_inc_s;
            if (win_inc_s == num_q) begin
              state_d = S_DRAIN;
              drain_d = 2'd0;
            end else begin
              state_d = S_RUN;
            end
          end else begin
            win_d = win_q;
          end
          case (tick_q)
            PAT_ONE:   data_d = PAT_ONE;
            PAT_TWO:   data_d = PAT_TWO;
            PAT_THREE: data_d = PAT_THREE;
            PAT_INJ: begin
              if (inj_q) begin
                data_d = {IO_SIZE_G{1'b1}};
                inj_d  = 1'b0;
              end else begin
                data_d = '0;
              end
            end
            default:   data_d = '0;
          endcase
        end
      end
      S_DRAIN: begin
        if (drain_q == 2'd2) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_q == S_RUN) || (state_q == S_DRAIN)) begin
      errd_d = err_data_i  ? sat_inc(errd_q) : errd_q;
      errs_d = err_state_i ? sat_inc(errs_q) : errs_q;
    end else begin
      errd_d = errd_d;
      errs_d = errs_d;
    end
  end

  // Output flags are derived from the next state so they line up with it
  always_comb begin
    chk_rst_d = (state_d == S_IDLE) || (state_d == S_ARM);
    busy_d    = (state_d == S_ARM) || (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d    = (state_d == S_DONE) && (state_q != S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      arm_q     <= 1'b0;
      drain_q   <= 2'd0;
      tick_q    <= '0;
      inj_q     <= 1'b0;
      num_q     <= '0;
      win_q     <= '0;
      errd_q    <= '0;
      errs_q    <= '0;
      data_q    <= '0;
      chk_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      arm_q     <= arm_d;
      drain_q   <= drain_d;
      tick_q    <= tick_d;
      inj_q     <= inj_d;
      num_q     <= num_d;
      win_q     <= win_d;
      errd_q    <= errd_d;
      errs_q    <= errs_d;
      data_q    <= data_d;
      chk_rst_q <= chk_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign chk_rst_o       = chk_rst_q;
  assign data_o          = data_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign win_cnt_o       = win_q;
  assign err_data_cnt_o  = errd_q;
  assign err_state_cnt_o = errs_q;

endmodule
